// File: rtl/cache_pkg.sv
// Shared types and width helpers for the N-way set-associative cache.
// state_t : controller states (IDLE, COMPARE, WRITEBACK, FILL)
// idx_w   : set-index width, 0 for a fully associative cache
// way_w   : way-index / LRU-age width
// tag_w   : tag width, everything above the index
package cache_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    COMPARE   = 2'd1,
    WRITEBACK = 2'd2,
    FILL      = 2'd3
  } state_t;

  function automatic int idx_w(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int way_w(input int ways);
    return $clog2(ways);
  endfunction

  function automatic int tag_w(input int addr_w, input int sets);
    return addr_w - $clog2(sets);
  endfunction

endpackage

// File: rtl/cache_nvias_lru.sv
// True-LRU age tracking for every set.
// clock, resetn : rising-edge clock, async active-low reset
// set           : set being looked up / touched
// touch         : strobe, an access to touch_way completes this cycle
// touch_way     : way that was accessed
// victim        : way in 'set' holding age WAYS-1 (least recently used)
// Ages within a set are always a permutation of 0..WAYS-1; age 0 is MRU.
module lru_ages #(
  parameter int WAYS  = 2,
  parameter int SETS  = 4,
  parameter int WAY_W = 1,
  parameter int SET_W = 2
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic [SET_W-1:0] set,
  input  logic             touch,
  input  logic [WAY_W-1:0] touch_way,
  output logic [WAY_W-1:0] victim
);

  logic [SETS-1:0][WAYS-1:0][WAY_W-1:0] age;
  logic [WAY_W-1:0]                     old_age;

  assign old_age = age[set][touch_way];

  always_comb begin
    victim = '0;
    for (int w = 0; w < WAYS; w++)
      if (age[set][w] == WAY_W'(WAYS - 1)) victim = WAY_W'(w);
  end

  // Touched way becomes MRU; only ways younger than it age by one,
  // which keeps the ages a permutation.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int s = 0; s < SETS; s++)
        for (int w = 0; w < WAYS; w++)
          age[s][w] <= WAY_W'(w);
    end else if (touch) begin
      for (int w = 0; w < WAYS; w++) begin
        if (WAY_W'(w) == touch_way)
          age[set][w] <= '0;
        else if (age[set][w] < old_age)
          age[set][w] <= age[set][w] + 1'b1;
      end
    end
  end

endmodule

// File: rtl/cache_nvias.sv
// N-way set-associative write-back / write-allocate cache, one word per line.
// clock, resetn          : rising-edge clock, async active-low reset
// cpu_req/we/addr/wdata  : request, sampled only in IDLE
// cpu_ready              : one-cycle completion pulse
// cpu_rdata, hit, dirty  : response, valid with cpu_ready
// mem_req/we/addr/wdata  : memory request, held until mem_ack
// mem_ack, mem_rdata     : memory completion and fill data
module cache_nvias
  import cache_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 13,
  parameter int WAYS   = 2,
  parameter int SETS   = 4
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ready,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              hit,
  output logic              dirty,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int IDX_W = idx_w(SETS);
  localparam int WAY_W = way_w(WAYS);
  localparam int TAG_W = tag_w(ADDR_W, SETS);
  localparam int SET_W = (IDX_W > 0) ? IDX_W : 1;

  state_t state, state_nxt;

  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              miss_flag;   // sticky: this request missed at least once
  logic [WAY_W-1:0]  vic_way;

  logic [SET_W-1:0]  idx;
  logic [TAG_W-1:0]  tag;

  logic [TAG_W-1:0]  tag_mem  [SETS][WAYS];
  logic [DATA_W-1:0] data_mem [SETS][WAYS];
  logic [SETS-1:0][WAYS-1:0] valid;
  logic [SETS-1:0][WAYS-1:0] dirty_bits;

  logic [WAYS-1:0]   way_hit;
  logic              hit_any;
  logic [WAY_W-1:0]  hit_way;
  logic              has_inv;
  logic [WAY_W-1:0]  inv_way;
  logic [WAY_W-1:0]  lru_victim;
  logic [WAY_W-1:0]  miss_way;
  logic [ADDR_W-1:0] vic_addr;

  // Fully associative build has no index bits; everything lives in set 0.
  generate
    if (IDX_W > 0) begin : g_idx
      assign idx      = req_addr[IDX_W-1:0];
      assign vic_addr = {tag_mem[idx][vic_way], idx};
    end else begin : g_noidx
      assign idx      = '0;
      assign vic_addr = tag_mem[idx][vic_way];
    end
  endgenerate

  assign tag = req_addr[ADDR_W-1:IDX_W];

  genvar gw;
  generate
    for (gw = 0; gw < WAYS; gw++) begin : g_way
      assign way_hit[gw] = valid[idx][gw] && (tag_mem[idx][gw] == tag);
    end
  endgenerate

  // Lowest-index hit / invalid way wins (descending scan).
  always_comb begin
    hit_way = '0;
    inv_way = '0;
    has_inv = 1'b0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (way_hit[w]) hit_way = WAY_W'(w);
      if (!valid[idx][w]) begin
        inv_way = WAY_W'(w);
        has_inv = 1'b1;
      end
    end
  end

  assign hit_any  = |way_hit;
  assign miss_way = has_inv ? inv_way : lru_victim;

  lru_ages #(
    .WAYS (WAYS),
    .SETS (SETS),
    .WAY_W(WAY_W),
    .SET_W(SET_W)
  ) u_lru (
    .clock    (clock),
    .resetn   (resetn),
    .set      (idx),
    .touch    (state == COMPARE && hit_any),
    .touch_way(hit_way),
    .victim   (lru_victim)
  );

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (cpu_req) state_nxt = COMPARE;
      COMPARE: begin
        if (hit_any)
          state_nxt = IDLE;
        else if (valid[idx][miss_way] && dirty_bits[idx][miss_way])
          state_nxt = WRITEBACK;
        else
          state_nxt = FILL;
      end
      WRITEBACK: if (mem_ack) state_nxt = FILL;
      FILL:      if (mem_ack) state_nxt = COMPARE;
      default:   state_nxt = IDLE;
    endcase
  end

  // Memory port decoded from state and latched request/victim only, so it
  // is stable across wait states and drops with the async reset.
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state)
      WRITEBACK: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = vic_addr;
        mem_wdata = data_mem[idx][vic_way];
      end
      FILL: begin
        mem_req  = 1'b1;
        mem_addr = req_addr;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      req_we     <= 1'b0;
      req_addr   <= '0;
      req_wdata  <= '0;
      miss_flag  <= 1'b0;
      vic_way    <= '0;
      cpu_ready  <= 1'b0;
      cpu_rdata  <= '0;
      hit        <= 1'b0;
      dirty      <= 1'b0;
      valid      <= '0;
      dirty_bits <= '0;
    end else begin
      cpu_ready <= 1'b0;
      cpu_rdata <= '0;
      hit       <= 1'b0;
      dirty     <= 1'b0;
      case (state)
        IDLE: if (cpu_req) begin
          req_we    <= cpu_we;
          req_addr  <= cpu_addr;
          req_wdata <= cpu_wdata;
          miss_flag <= 1'b0;
        end
        COMPARE: begin
          if (hit_any) begin
            cpu_ready <= 1'b1;
            hit       <= ~miss_flag;
            if (req_we) begin
              cpu_rdata                <= req_wdata;
              dirty                    <= 1'b1;
              dirty_bits[idx][hit_way] <= 1'b1;
            end else begin
              cpu_rdata <= data_mem[idx][hit_way];
              dirty     <= dirty_bits[idx][hit_way];
            end
          end else begin
            miss_flag <= 1'b1;
            vic_way   <= miss_way;
          end
        end
        FILL: if (mem_ack) begin
          valid[idx][vic_way]      <= 1'b1;
          dirty_bits[idx][vic_way] <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Line storage is not reset; valid bits gate its use.
  always_ff @(posedge clock) begin
    if (state == COMPARE && hit_any && req_we)
      data_mem[idx][hit_way] <= req_wdata;
    if (state == FILL && mem_ack) begin
      data_mem[idx][vic_way] <= mem_rdata;
      tag_mem[idx][vic_way]  <= tag;
    end
  end

endmodule

// File: tb/tb_cache_nvias.sv
// Directed bench for cache_nvias (defaults: 2 ways, 4 sets, 5-bit addr,
// 13-bit data) with a wait-state-programmable backing memory.
module tb_cache_nvias;

  logic        clock;
  logic        resetn;
  logic        cpu_req, cpu_we;
  logic [4:0]  cpu_addr;
  logic [12:0] cpu_wdata;
  logic        cpu_ready;
  logic [12:0] cpu_rdata;
  logic        hit, dirty;
  logic        mem_req, mem_we;
  logic [4:0]  mem_addr;
  logic [12:0] mem_wdata;
  logic        mem_ack;
  logic [12:0] mem_rdata;

  cache_nvias dut (
    .clock    (clock),
    .resetn   (resetn),
    .cpu_req  (cpu_req),
    .cpu_we   (cpu_we),
    .cpu_addr (cpu_addr),
    .cpu_wdata(cpu_wdata),
    .cpu_ready(cpu_ready),
    .cpu_rdata(cpu_rdata),
    .hit      (hit),
    .dirty    (dirty),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_ack  (mem_ack),
    .mem_rdata(mem_rdata)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Backing memory: acks after mem_wait idle cycles, logs traffic.
  logic [12:0] mem_arr [32];
  int          mem_wait  = 0;
  int          wcnt      = 0;
  int          n_wb      = 0;
  int          n_fill    = 0;
  int          req_cyc   = 0;
  logic [4:0]  wb_addr   = '0;
  logic [12:0] wb_data   = '0;
  logic [4:0]  fill_addr = '0;

  initial begin
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clock); #1;
      if (!resetn) begin
        mem_ack = 1'b0;
        wcnt    = 0;
      end else if (mem_ack) begin
        mem_ack = 1'b0;
      end else if (mem_req) begin
        req_cyc++;
        if (wcnt < mem_wait) wcnt++;
        else begin
          wcnt = 0;
          if (mem_we) begin
            mem_arr[mem_addr] = mem_wdata;
            wb_addr = mem_addr;
            wb_data = mem_wdata;
            n_wb++;
          end else begin
            mem_rdata = mem_arr[mem_addr];
            fill_addr = mem_addr;
            n_fill++;
          end
          mem_ack = 1'b1;
        end
      end
    end
  end

  logic        r_got, r_hit, r_dirty;
  logic [12:0] r_rdata;
  int          lat;

  // One request, then wait (bounded) for cpu_ready; lat counts edges
  // after the accepting edge.
  task automatic access(input logic we, input logic [4:0] a, input logic [12:0] d);
    @(posedge clock); #1;
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
    @(posedge clock); #1;
    cpu_req = 1'b0;
    lat = 0; r_got = 1'b0; r_hit = 1'b0; r_dirty = 1'b0; r_rdata = '0;
    while (!r_got && lat < 100) begin
      @(posedge clock); #1;
      lat++;
      if (cpu_ready) begin
        r_got = 1'b1; r_hit = hit; r_dirty = dirty; r_rdata = cpu_rdata;
      end
    end
    chk("ready_seen", r_got, 1'b1);
  endtask

  int f0, w0, q0, n, rdy_seen;

  initial begin
    for (int i = 0; i < 32; i++) mem_arr[i] = 13'h100 + 13'(i);
    mem_arr[1] = 13'h0AA;
    resetn = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    #13;
    chk("rst_ready", cpu_ready, 0);
    chk("rst_memreq", mem_req, 0);
    chk("rst_hit", hit, 0);
    chk("rst_dirty", dirty, 0);
    chk("rst_rdata", cpu_rdata, 0);
    #9 resetn = 1'b1;

    // 1: cold read miss with 3 wait states, then reread hit
    mem_wait = 3; f0 = n_fill;
    access(1'b0, 5'h01, 13'h0);
    chk("t1_fill_addr", fill_addr, 5'h01);
    chk("t1_fill_cnt", n_fill - f0, 1);
    chk("t1_rdata", r_rdata, 13'h0AA);
    chk("t1_hit", r_hit, 0);
    chk("t1_dirty", r_dirty, 0);
    q0 = req_cyc;
    access(1'b0, 5'h01, 13'h0);
    chk("t1_re_lat", lat, 1);
    chk("t1_re_hit", r_hit, 1);
    chk("t1_re_rdata", r_rdata, 13'h0AA);
    chk("t1_re_noreq", req_cyc - q0, 0);

    // 2: write hit
    q0 = req_cyc;
    access(1'b1, 5'h01, 13'h1234);
    chk("t2_hit", r_hit, 1);
    chk("t2_dirty", r_dirty, 1);
    chk("t2_rdata", r_rdata, 13'h1234);
    chk("t2_lat", lat, 1);
    chk("t2_noreq", req_cyc - q0, 0);

    // 3: set 1 conflict, clean eviction, zero-wait memory
    mem_wait = 0; w0 = n_wb;
    access(1'b0, 5'h05, 13'h0);
    chk("t3_05_hit", r_hit, 0);
    chk("t3_05_rdata", r_rdata, 13'h105);
    access(1'b0, 5'h01, 13'h0);
    chk("t3_01_hit", r_hit, 1);
    chk("t3_01_rdata", r_rdata, 13'h1234);
    chk("t3_01_dirty", r_dirty, 1);
    access(1'b0, 5'h09, 13'h0);
    chk("t3_09_hit", r_hit, 0);
    chk("t3_09_rdata", r_rdata, 13'h109);
    chk("t3_09_fill", fill_addr, 5'h09);
    chk("t3_no_wb", n_wb - w0, 0);

    // 4: dirty victim write-back then fill
    mem_wait = 2; w0 = n_wb;
    access(1'b0, 5'h0D, 13'h0);
    chk("t4_wb_cnt", n_wb - w0, 1);
    chk("t4_wb_addr", wb_addr, 5'h01);
    chk("t4_wb_data", wb_data, 13'h1234);
    chk("t4_fill", fill_addr, 5'h0D);
    chk("t4_hit", r_hit, 0);
    chk("t4_dirty", r_dirty, 0);
    chk("t4_rdata", r_rdata, 13'h10D);

    // 5: write miss with cpu_req held high throughout
    mem_wait = 1; f0 = n_fill;
    @(posedge clock); #1;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 5'h02; cpu_wdata = 13'h0F0F;
    r_got = 1'b0; n = 0;
    while (!r_got && n < 100) begin
      @(posedge clock); #1;
      n++;
      if (cpu_ready) begin
        r_got = 1'b1; r_hit = hit; r_dirty = dirty; r_rdata = cpu_rdata;
      end
    end
    chk("t5_ready", r_got, 1'b1);
    chk("t5_hit", r_hit, 0);
    chk("t5_dirty", r_dirty, 1);
    chk("t5_rdata", r_rdata, 13'h0F0F);
    chk("t5_fill_cnt", n_fill - f0, 1);
    chk("t5_fill_addr", fill_addr, 5'h02);
    @(posedge clock); #1;
    chk("t5_gap", cpu_ready, 0);
    @(posedge clock); #1;
    chk("t5_second_rdy", cpu_ready, 1);
    chk("t5_second_hit", hit, 1);
    chk("t5_second_dirty", dirty, 1);
    cpu_req = 1'b0;
    chk("t5_fill_cnt2", n_fill - f0, 1);

    // 6: reset during FILL
    mem_wait = 3;
    @(posedge clock); #1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 5'h11;
    @(posedge clock); #1;
    cpu_req = 1'b0;
    n = 0;
    while (!mem_req && n < 20) begin
      @(posedge clock); #1;
      n++;
    end
    chk("t6_fill_seen", mem_req, 1);
    chk("t6_fill_we", mem_we, 0);
    chk("t6_fill_addr", mem_addr, 5'h11);
    #2 resetn = 1'b0;
    #1;
    chk("t6_rst_memreq", mem_req, 0);
    chk("t6_rst_ready", cpu_ready, 0);
    @(posedge clock); @(posedge clock); #3;
    resetn = 1'b1;
    rdy_seen = 0;
    repeat (6) begin
      @(posedge clock); #1;
      if (cpu_ready) rdy_seen++;
    end
    chk("t6_no_ready", rdy_seen, 0);
    mem_wait = 0;
    access(1'b0, 5'h01, 13'h0);
    chk("t6_hit", r_hit, 0);
    chk("t6_rdata", r_rdata, 13'h1234);
    chk("t6_fill", fill_addr, 5'h01);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cache_nvias.md
Name: cache_nvias

Overview:
- Parametrised N-way set-associative cache, write-back / write-allocate, true-LRU replacement, one word per line.
- Successor to the fixed 2-way board cache: width, ways and sets become parameters.
- Adds a CPU request/ready handshake and a memory-side req/ack port with real miss handling: fill, and dirty-victim write-back.
- Sits between the switch/key front end (or a CPU) and a backing memory model; hit/dirty feed board LEDs as before.

Parameters:
- ADDR_W, 5, address width; index = addr[IDX_W-1:0], tag = addr[ADDR_W-1:IDX_W].
- DATA_W, 13, data word width.
- WAYS, 2, associativity; power of 2, at least 2.
- SETS, 4, number of sets; power of 2, at least 1 (SETS=1 means fully associative, IDX_W=0).

Ports:
- clock  in  1  rising-edge clock.
- resetn  in  1  asynchronous, active-low reset.
- cpu_req  in  1  request strobe, sampled only in IDLE.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  ADDR_W  request address.
- cpu_wdata  in  DATA_W  write data.
- cpu_ready  out  1  one-cycle completion pulse.
- cpu_rdata  out  DATA_W  line data after the access (written data on a write).
- hit  out  1  1 if the first lookup of this request hit.
- dirty  out  1  dirty bit of the accessed line after the access.
- mem_req  out  1  memory request, held until mem_ack.
- mem_we  out  1  1 = write-back, 0 = fill.
- mem_addr  out  ADDR_W  memory address, stable while mem_req=1.
- mem_wdata  out  DATA_W  victim data during write-back.
- mem_ack  in  1  one-cycle completion from memory; ignored when mem_req=0.
- mem_rdata  in  DATA_W  fill data, valid with mem_ack.

Behaviour:
- Reset (asynchronous, resetn=0):
  - State IDLE.
  - All valid and dirty bits cleared.
  - LRU age of way w set to w in every set.
  - All outputs 0; mem_req drops immediately.
  - Data and tag arrays are not reset.
  - Reset mid-transaction abandons it; no ack or ready follows.
- FSM states: IDLE, COMPARE, WRITEBACK, FILL.
- IDLE: cpu_req=1 latches we/addr/wdata and moves to COMPARE. While not IDLE, cpu_req is ignored.
- COMPARE, hit (valid and tag match in some way):
  - Read returns the way's data.
  - Write stores cpu_wdata and sets dirty=1.
  - LRU is updated; go to IDLE.
  - cpu_ready, cpu_rdata, hit, dirty are registered; they are valid for exactly one cycle after the edge leaving COMPARE.
  - hit latency: request sampled at edge N, response visible after edge N+1. A new request can be accepted in the ready cycle.
- COMPARE, miss, victim selection:
  - Victim is the lowest-index invalid way; if none, the way with age WAYS-1.
  - Victim valid and dirty: go to WRITEBACK.
  - Otherwise: go to FILL.
- WRITEBACK:
  - Drives mem_req=1, mem_we=1, mem_addr={victim tag, index}, mem_wdata=victim data.
  - On mem_ack, go to FILL.
- FILL:
  - Drives mem_req=1, mem_we=0, mem_addr=latched addr.
  - On mem_ack, install mem_rdata with tag, valid=1, dirty=0; go to COMPARE.
  - The re-lookup hits and completes as a hit path, but the reported hit is 0 (sticky miss flag cleared on acceptance). A write miss therefore ends with dirty=1.
- mem_ack in the first cycle of mem_req is legal (zero-wait memory). Arbitrary wait states hold all mem_* outputs stable.
- LRU: per set, WAYS counters of WAY_W bits, always a permutation of 0..WAYS-1.
  - On every completing access to way k: ages below old age[k] increment, age[k]=0.
  - Fills do not separately update LRU; the re-lookup does.
- Width rules: TAG_W = ADDR_W - IDX_W; tags compare at full TAG_W width; no arithmetic overflow paths.

Decomposition:
- Package cache_pkg holds:
  - state enum {IDLE, COMPARE, WRITEBACK, FILL};
  - functions/localparams IDX_W=$clog2(SETS), WAY_W=$clog2(WAYS), TAG_W.
- Sub-module lru_ages (per-set age array, victim output, update on a touch strobe with way index).
- Tag/data/valid/dirty arrays and the FSM stay in cache_nvias.

Test Plan:
All scenarios use defaults (index = addr[1:0], tag = addr[4:2]).
1. Reset, read 5'h01; memory returns 13'h0AA after 3 wait cycles.
   -> FILL with mem_addr=5'h01; cpu_rdata=0AA, hit=0, dirty=0.
   -> Reread: ready after edge N+1, hit=1, no mem_req.
2. Write 5'h01 = 13'h1234 (hit).
   -> hit=1, dirty=1, cpu_rdata=1234, mem_req stays 0.
3. Read 5'h05, then read 5'h01, then read 5'h09 (all set 1).
   -> 05 fills way1; after the 01 hit, 09 evicts clean way1 with no write-back (mem_we never 1).
4. Read 5'h0D.
   -> Victim is dirty 01: WRITEBACK mem_addr=01, mem_wdata=1234, then FILL mem_addr=0D; hit=0, dirty=0.
5. Write miss 5'h02 = 13'h0F0F, with cpu_req held high throughout.
   -> FILL, then ready with hit=0, dirty=1; a second request is not accepted until IDLE.
6. resetn pulsed low during FILL.
   -> mem_req=0 same cycle, no cpu_ready; after release, read 5'h01 misses (hit=0).
